// File: rtl/uart_frame_controller.sv
// uart_frame_controller: collects N_IN RX bytes into a frame, runs the compute engine once,
// then streams its N_OUT result bytes to the UART TX with busy-based flow control.
module uart_frame_controller #(
    parameter int N_IN           = 1152,
    parameter int N_OUT          = 10,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       rx_data,
    input  logic                    rx_valid,
    output logic [N_IN*DATA_W-1:0]  in_vec,
    output logic                    compute_start,
    input  logic                    compute_done,
    input  logic [N_OUT*DATA_W-1:0] out_vec,
    output logic [DATA_W-1:0]       tx_data,
    output logic                    tx_enable,
    input  logic                    tx_busy,
    output logic                    busy,
    output logic                    frame_err,
    output logic [15:0]             frames_done
);
    localparam int RX_W = N_IN > 1 ? $clog2(N_IN) : 1;
    localparam int TX_W = N_OUT > 1 ? $clog2(N_OUT) : 1;
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [RX_W-1:0] RX_LAST = RX_W'(N_IN - 1);
    localparam logic [TX_W-1:0] TX_LAST = TX_W'(N_OUT - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RECV, START, COMPUTE, SEND, ACK, DRAIN} state_t;

    state_t                  state;
    logic [RX_W-1:0]         rx_cnt;
    logic [TO_W-1:0]         to_cnt;
    logic [TX_W-1:0]         tx_idx;
    logic [1:0]              ack_cnt;
    logic [N_OUT*DATA_W-1:0] out_buf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            in_vec        <= '0;
            out_buf       <= '0;
            tx_data       <= '0;
            frames_done   <= '0;
            rx_cnt        <= '0;
            to_cnt        <= '0;
            tx_idx        <= '0;
            ack_cnt       <= '0;
            compute_start <= 1'b0;
            tx_enable     <= 1'b0;
            busy          <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            compute_start <= 1'b0;
            tx_enable     <= 1'b0;
            // bytes arriving while the frame is being processed are dropped as overruns
            if (rx_valid && state != IDLE && state != RECV) frame_err <= 1'b1;
            case (state)
                IDLE: if (rx_valid) begin
                    in_vec[DATA_W-1:0] <= rx_data;
                    frame_err <= 1'b0;
                    rx_cnt    <= RX_W'(1);
                    to_cnt    <= '0;
                    busy      <= 1'b1;
                    if (N_IN == 1) begin
                        rx_cnt        <= '0;
                        compute_start <= 1'b1;
                        state         <= START;
                    end else state <= RECV;
                end
                RECV: if (rx_valid) begin
                    in_vec[rx_cnt*DATA_W +: DATA_W] <= rx_data;
                    to_cnt <= '0;
                    if (rx_cnt == RX_LAST) begin
                        rx_cnt        <= '0;
                        compute_start <= 1'b1;
                        state         <= START;
                    end else rx_cnt <= rx_cnt + 1'b1;
                end else if (to_cnt == TO_LAST) begin
                    frame_err <= 1'b1;
                    rx_cnt    <= '0;
                    to_cnt    <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end else to_cnt <= to_cnt + 1'b1;
                START: state <= COMPUTE;
                COMPUTE: if (compute_done) begin
                    out_buf <= out_vec;
                    tx_idx  <= '0;
                    state   <= SEND;
                end
                SEND: if (!tx_busy) begin
                    tx_data   <= out_buf[tx_idx*DATA_W +: DATA_W];
                    tx_enable <= 1'b1;
                    ack_cnt   <= '0;
                    state     <= ACK;
                end
                // a UART that never raises busy must not stall the frame
                ACK: if (tx_busy || ack_cnt == 2'd3) state <= DRAIN;
                     else ack_cnt <= ack_cnt + 1'b1;
                DRAIN: if (!tx_busy) begin
                    if (tx_idx == TX_LAST) begin
                        tx_idx      <= '0;
                        frames_done <= frames_done + 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tx_idx <= tx_idx + 1'b1;
                        state  <= SEND;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_frame_controller.sv
// tb_uart_frame_controller: vector table, corner sequences and randomized frames
// checked against a frame-level model of byte collection, result transmission and counting.
module tb_uart_frame_controller;
    localparam int N_IN = 4;
    localparam int N_OUT = 3;
    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [31:0] in_vec;
    logic        compute_start;
    logic        compute_done = 1'b0;
    logic [23:0] out_vec = '0;
    logic [7:0]  tx_data;
    logic        tx_enable;
    logic        tx_busy = 1'b0;
    logic        busy;
    logic        frame_err;
    logic [15:0] frames_done;

    int          checks = 0;
    int          failures = 0;
    int          cs_cnt = 0;
    int          tx_left = 0;
    bit          tx_mute = 1'b0;
    logic [7:0]  txq[$];
    logic [15:0] exp_frames = '0;

    typedef struct {
        logic [31:0] rx;
        logic [23:0] ov;
        int          gap;
        int          clat;
        bit          ovr;
        bit          mute;
        bit          abort;
        logic [31:0] exp_in;
        logic [23:0] exp_tx;
        bit          exp_err;
    } vec_t;

    uart_frame_controller #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .in_vec(in_vec),
        .compute_start(compute_start), .compute_done(compute_done), .out_vec(out_vec),
        .tx_data(tx_data), .tx_enable(tx_enable), .tx_busy(tx_busy), .busy(busy),
        .frame_err(frame_err), .frames_done(frames_done)
    );

    always #5 clk = ~clk;

    // UART TX model: busy from the edge after an enable for 20 cycles, unless muted
    always @(posedge clk) begin
        if (tx_enable && !tx_mute) begin
            tx_busy <= 1'b1;
            tx_left <= 20;
        end else if (tx_left > 0) begin
            tx_left <= tx_left - 1;
            if (tx_left == 1) tx_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (tx_enable) txq.push_back(tx_data);
        if (compute_start) cs_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        chk({tag, " idle bound"}, 64'(busy), 64'(0));
    endtask

    // reference model: arrival order fills in_vec from the LSB; result bytes leave LSB first
    function automatic logic [31:0] model_in(input logic [7:0] q[$]);
        logic [31:0] r;
        r = '0;
        foreach (q[k]) r = r | (32'(q[k]) << (8 * k));
        return r;
    endfunction

    function automatic logic [23:0] model_tx(input logic [23:0] ov);
        logic [23:0] r;
        r = '0;
        for (int k = 0; k < N_OUT; k++) r = {r[15:0], 8'((ov >> (8 * k)) & 24'hFF)};
        return r;
    endfunction

    task automatic run_frame(input vec_t v, input string tag);
        logic [31:0] b;
        b = v.rx;
        txq.delete();
        tx_mute = v.mute;
        for (int k = 0; k < N_IN; k++) begin
            send_byte(b[8*k +: 8]);
            if (k == 0) begin
                chk({tag, " err cleared"}, 64'(frame_err), 64'(0));
                chk({tag, " busy"}, 64'(busy), 64'(1));
            end
            if (k < N_IN - 1) tick(v.gap);
        end
        chk({tag, " start latency"}, 64'(compute_start), 64'(1));
        chk({tag, " in_vec"}, 64'(in_vec), 64'(v.exp_in));
        tick();
        chk({tag, " start width"}, 64'(compute_start), 64'(0));
        if (v.ovr) send_byte(8'hEE);
        tick(v.clat);
        out_vec = v.ov;
        compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
        out_vec = 24'($urandom);
        wait_idle(tag);
        exp_frames++;
        chk({tag, " tx count"}, 64'(txq.size()), 64'(N_OUT));
        for (int k = 0; k < N_OUT; k++)
            chk({tag, " tx byte"}, 64'(txq.size() > k ? txq[k] : 8'hxx), 64'(v.exp_tx[23-8*k -: 8]));
        chk({tag, " frame_err"}, 64'(frame_err), 64'(v.exp_err));
        chk({tag, " in_vec kept"}, 64'(in_vec), 64'(v.exp_in));
        chk({tag, " frames_done"}, 64'(frames_done), 64'(exp_frames));
    endtask

    initial begin
        vec_t tab[4];
        vec_t v;
        logic [7:0] rq[$];
        int cs0;
        int n;
        tab[0] = '{rx:32'h44332211, ov:24'hCCBBAA, gap:0, clat:2, ovr:0, mute:0, abort:0,
                   exp_in:32'h44332211, exp_tx:24'hAABBCC, exp_err:0};
        tab[1] = '{rx:32'h04030201, ov:24'h0A0B0C, gap:1, clat:0, ovr:0, mute:0, abort:1,
                   exp_in:32'h04030201, exp_tx:24'h0C0B0A, exp_err:0};
        tab[2] = '{rx:32'hDEADBEEF, ov:24'h123456, gap:0, clat:3, ovr:1, mute:0, abort:0,
                   exp_in:32'hDEADBEEF, exp_tx:24'h563412, exp_err:1};
        tab[3] = '{rx:32'h80FF017F, ov:24'hFF0080, gap:TO-1, clat:5, ovr:0, mute:1, abort:0,
                   exp_in:32'h80FF017F, exp_tx:24'h8000FF, exp_err:0};

        tick(2);
        chk("reset outputs", 64'({in_vec, tx_data, frames_done, compute_start, tx_enable, busy, frame_err}), 64'(0));
        rst_n = 1'b1;
        tick();
        compute_done = 1'b1;
        tick(3);
        compute_done = 1'b0;
        tick();
        chk("done in idle busy", 64'(busy), 64'(0));
        chk("done in idle tx", 64'(txq.size()), 64'(0));

        for (int i = 0; i < 4; i++) begin
            if (tab[i].abort) begin
                send_byte(8'h99);
                send_byte(8'h98);
                tick(TO - 1);
                chk("timeout early busy", 64'(busy), 64'(1));
                chk("timeout early err", 64'(frame_err), 64'(0));
                tick();
                chk("timeout err", 64'(frame_err), 64'(1));
                chk("timeout idle", 64'(busy), 64'(0));
            end
            run_frame(tab[i], $sformatf("vec%0d", i));
        end

        // asynchronous reset while draining the second result byte
        txq.delete();
        tx_mute = 1'b0;
        for (int k = 0; k < N_IN; k++) send_byte(8'h50 + 8'(k));
        tick();
        out_vec = 24'h332211;
        compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
        n = 0;
        while (txq.size() < 2 && n < 200) begin
            tick();
            n++;
        end
        chk("rst 2nd byte seen", 64'(txq.size()), 64'(2));
        tick(3);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset", 64'({in_vec, tx_data, frames_done, compute_start, tx_enable, busy, frame_err}), 64'(0));
        tick(2);
        rst_n = 1'b1;
        cs0 = cs_cnt;
        tick(60);
        chk("rst no more tx", 64'(txq.size()), 64'(2));
        chk("rst no start", 64'(cs_cnt), 64'(cs0));
        chk("rst idle", 64'(busy), 64'(0));
        exp_frames = '0;
        run_frame(tab[0], "post-reset");

        // frame counter wrap
        force dut.frames_done = 16'hFFFE;
        tick();
        release dut.frames_done;
        tick();
        chk("wrap preset", 64'(frames_done), 64'(16'hFFFE));
        exp_frames = 16'hFFFE;
        run_frame(tab[1], "wrap1");
        chk("wrap FFFF", 64'(frames_done), 64'(16'hFFFF));
        run_frame(tab[0], "wrap2");
        chk("wrap 0000", 64'(frames_done), 64'(16'h0000));
        run_frame(tab[3], "wrap3");
        chk("wrap 0001", 64'(frames_done), 64'(16'h0001));

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                cs0 = cs_cnt;
                n = $urandom_range(1, N_IN - 1);
                for (int k = 0; k < n; k++) begin
                    send_byte(8'($urandom));
                    if (k < n - 1) tick($urandom_range(0, 5));
                end
                tick(TO);
                chk("rnd abort err", 64'(frame_err), 64'(1));
                chk("rnd abort idle", 64'(busy), 64'(0));
                chk("rnd abort no start", 64'(cs_cnt), 64'(cs0));
            end
            v.rx = $urandom;
            v.ov = 24'($urandom);
            v.gap = ($urandom_range(0, 7) == 0) ? TO - 1 : $urandom_range(0, 5);
            v.clat = $urandom_range(0, 8);
            v.ovr = 1'($urandom_range(0, 1));
            v.mute = ($urandom_range(0, 3) == 0);
            v.abort = 1'b0;
            rq.delete();
            for (int k = 0; k < N_IN; k++) rq.push_back(8'(v.rx >> (8 * k)));
            v.exp_in = model_in(rq);
            v.exp_tx = model_tx(v.ov);
            v.exp_err = v.ovr;
            run_frame(v, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
